// File: rtl/mux4_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux4_sched_pkg
// Description : Shared types and constants for the 4-input round-robin
//               mux scheduler. Holds the scheduler state type, the number
//               of requesters and the select width.
// Revision    : 1.0 - initial release
// ============================================================================
package mux4_sched_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    // Scheduler state: IDLE has no owner, GRANT has exactly one owner.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

endpackage : mux4_sched_pkg
`default_nettype wire

// File: rtl/mux4_rr_sched_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational round-robin winner search over four request
//               lines. Starting after the last granted index, the lines are
//               examined in the order ptr+1, ptr+2, ptr+3, ptr (mod 4) and
//               the first set bit wins.
// Ports       : req_mask   [3:0] in  - candidate request lines
//               ptr        [1:0] in  - last granted index
//               win_onehot [3:0] out - one-hot winner (zero if none)
//               win_idx    [1:0] out - binary winner index (0 if none)
//               win_valid        out - at least one candidate was set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
    import mux4_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req_mask,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_REQ-1:0] win_onehot,
    output logic [SEL_W-1:0] win_idx,
    output logic             win_valid
);

    logic [SEL_W-1:0] w_cand;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        w_cand     = '0;
        // The 2-bit add wraps naturally, so k = N_REQ lands back on ptr,
        // which makes the last granted index the lowest priority.
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = ptr + SEL_W'(k);
            if (!win_valid && req_mask[w_cand]) begin
                win_valid          = 1'b1;
                win_idx            = w_cand;
                win_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/mux4_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_sched
// Description : Round-robin scheduler that owns a shared 4:1 mux. One
//               requester at a time holds the grant; on release the grant
//               moves directly to the next round-robin winner without an
//               idle cycle. The muxed data bit is registered (1-cycle
//               latency after the select).
// Config      : define MUX4_SCHED_TIMEOUT_EN to compile in an 8-bit hold
//               counter that forces rotation after MAX_HOLD consecutive
//               grant cycles when another requester is waiting.
// Parameters  : MAX_HOLD (2..255) - grant cycles per owner with timeout
// Ports       : clk        in  - clock, rising edge
//               rst_n      in  - synchronous active-low reset
//               req  [3:0] in  - per-requester request
//               din  [3:0] in  - per-requester mux data bit
//               gnt  [3:0] out - one-hot grant, zero when idle
//               sel  [1:0] out - binary index of owner, holds when idle
//               y          out - registered mux output
//               busy       out - high while a grant is active
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_sched
    import mux4_sched_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             y,
    output logic             busy
);

    localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [N_REQ-1:0] w_mask;
    logic [N_REQ-1:0] w_win_onehot;
    logic [SEL_W-1:0] w_win_idx;
    logic             w_win_valid;
    logic             w_owner_req;
    logic             w_rotate;
    logic             w_new_grant;

    // While granted, the owner is removed from the search so that a
    // release or forced rotation can only pick a different requester.
    assign w_mask      = (r_state == GRANT) ? (req & ~gnt) : req;
    assign w_owner_req = |(req & gnt);

    rr_pick4 u_pick (
        .req_mask   (w_mask),
        .ptr        (r_ptr),
        .win_onehot (w_win_onehot),
        .win_idx    (w_win_idx),
        .win_valid  (w_win_valid)
    );

`ifdef MUX4_SCHED_TIMEOUT_EN
    logic [7:0] r_hold_cnt;

    // In GRANT the search mask excludes the owner, so win_valid already
    // means "someone else is waiting".
    assign w_rotate = (r_hold_cnt == c_HOLD_LAST) && w_win_valid;

    // Saturates at the rotation threshold so a late-arriving competitor
    // takes over at the very next edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else if (w_new_grant) begin
            r_hold_cnt <= '0;
        end else if (r_state == GRANT && r_hold_cnt != c_HOLD_LAST) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
        end
    end
`else
    logic w_unused_hold;

    assign w_rotate      = 1'b0;
    assign w_unused_hold = ^c_HOLD_LAST;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = gnt;
        w_sel_nxt   = sel;
        w_ptr_nxt   = r_ptr;
        w_new_grant = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win_valid) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = w_win_onehot;
                    w_sel_nxt   = w_win_idx;
                    w_ptr_nxt   = w_win_idx;
                    w_new_grant = 1'b1;
                end
            end
            GRANT: begin
                if (w_owner_req && !w_rotate) begin
                    // owner keeps the mux
                end else if (w_win_valid) begin
                    w_gnt_nxt   = w_win_onehot;
                    w_sel_nxt   = w_win_idx;
                    w_ptr_nxt   = w_win_idx;
                    w_new_grant = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // ptr resets to 3 so requester 0 is first in line after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            gnt     <= '0;
            sel     <= '0;
            r_ptr   <= 2'd3;
            busy    <= 1'b0;
            y       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            gnt     <= w_gnt_nxt;
            sel     <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            busy    <= |w_gnt_nxt;
            y       <= busy & din[sel];
        end
    end

endmodule : mux4_rr_sched
`default_nettype wire

// File: tb/tb_mux4_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_rr_sched
// Description : Self-checking bench for mux4_rr_sched. A behavioural owner /
//               pointer model predicts gnt, sel, busy and y every cycle;
//               directed sequences pin both DUT and model to literals, then
//               randomized req/din/reset traffic runs for 10k cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_sched;

    localparam int MAX_HOLD = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'd0;
    logic [3:0] din   = 4'd0;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       y;
    logic       busy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model state: owner index (-1 = none), last granted index, select,
    // cycles owned beyond the first (timeout build), registered data bit.
    int         m_owner    = -1;
    int         m_ptr      = 3;
    int         m_sel      = 0;
    int         m_hold     = 0;
    logic       m_y        = 1'b0;
    logic [3:0] m_req_prev = 4'd0;

    mux4_rr_sched #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .sel   (sel),
        .y     (y),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic int rr_search(input logic [3:0] mask, input int from);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (from + k) % 4;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_gnt();
        return (m_owner < 0) ? 4'd0 : 4'(1 << m_owner);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'd0;
        tick();
        rst_n = 1'b1;
    endtask

    // Behavioural model, advanced on each rising edge from sampled inputs.
    always @(posedge clk) begin : model
        logic [3:0] others;
        int         w;
        bit         keep;
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 3;
            m_sel   = 0;
            m_hold  = 0;
            m_y     = 1'b0;
        end else begin
            m_y = (m_owner >= 0) ? din[m_sel] : 1'b0;
            if (m_owner < 0) begin
                w = rr_search(req, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_sel = w; m_ptr = w; m_hold = 0;
                end
            end else begin
                others          = req;
                others[m_owner] = 1'b0;
                keep            = req[m_owner];
`ifdef MUX4_SCHED_TIMEOUT_EN
                if (m_hold == MAX_HOLD - 1 && others != 4'd0) keep = 1'b0;
`endif
                if (keep) begin
`ifdef MUX4_SCHED_TIMEOUT_EN
                    if (m_hold < MAX_HOLD - 1) m_hold++;
`endif
                end else begin
                    w = rr_search(others, m_ptr);
                    if (w >= 0) begin
                        m_owner = w; m_sel = w; m_ptr = w; m_hold = 0;
                    end else begin
                        m_owner = -1;
                    end
                end
            end
        end
        m_req_prev = rst_n ? req : 4'd0;
    end

    // Single compare process: DUT against model plus structural invariants.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("gnt", {4'd0, gnt}, {4'd0, m_gnt()});
            check("sel", {6'd0, sel}, 8'(m_sel));
            check("busy", {7'd0, busy}, {7'd0, m_owner >= 0});
            check("y", {7'd0, y}, {7'd0, m_y});
            check("onehot0", {7'd0, $onehot0(gnt)}, 8'd1);
            check("busy_eq_or", {7'd0, busy}, {7'd0, |gnt});
            check("gnt_to_idle_req", {4'd0, gnt & ~m_req_prev}, 8'd0);
        end
    end

    task automatic chk_gnt(input string name, input logic [3:0] exp);
        check({name, "_dut"}, {4'd0, gnt}, {4'd0, exp});
        check({name, "_model"}, {4'd0, m_gnt()}, {4'd0, exp});
    endtask

    logic [3:0] exp_ord [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_g;

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        cmp_en = 1'b1;
        chk_gnt("rst_gnt", 4'b0000);
        check("rst_sel", {6'd0, sel}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_y", {7'd0, y}, 8'd0);

        // First grant after reset goes to requester 0, data one cycle later.
        rst_n = 1'b1;
        req   = 4'b0001;
        din   = 4'b0001;
        tick();
        chk_gnt("first_gnt", 4'b0001);
        check("first_sel", {6'd0, sel}, 8'd0);
        check("first_busy", {7'd0, busy}, 8'd1);
        tick();
        check("first_y", {7'd0, y}, 8'd1);

        // All requesting, each owner releases after one cycle.
        do_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk_gnt("rr_order", exp_ord[k]);
            check("rr_busy", {7'd0, busy}, 8'd1);
            req = 4'b1111 & ~exp_ord[k];
            tick();
        end

        // Owner 2 holds, then releases; winner wraps 3,0,1 to index 1.
        do_reset();
        req = 4'b0100;
        tick();
        chk_gnt("own2", 4'b0100);
        req = 4'b0110;
        tick();
        chk_gnt("own2_hold", 4'b0100);
        req = 4'b0010;
        tick();
        chk_gnt("wrap_to1", 4'b0010);
        check("wrap_sel", {6'd0, sel}, 8'd1);
        check("wrap_busy", {7'd0, busy}, 8'd1);

        // Reset in the middle of requester 3's grant.
        do_reset();
        req = 4'b1000;
        din = 4'b1000;
        tick();
        chk_gnt("own3", 4'b1000);
        tick();
        check("own3_y", {7'd0, y}, 8'd1);
        rst_n = 1'b0;
        tick();
        chk_gnt("mid_rst_gnt", 4'b0000);
        check("mid_rst_busy", {7'd0, busy}, 8'd0);
        check("mid_rst_y", {7'd0, y}, 8'd0);
        rst_n = 1'b1;
        tick();
        chk_gnt("regrant3", 4'b1000);
        check("regrant3_sel", {6'd0, sel}, 8'd3);

        // Two constant requesters: timeout rotates, otherwise 0 holds.
        do_reset();
        req = 4'b0011;
        tick();
        for (int c = 0; c < 16; c++) begin
`ifdef MUX4_SCHED_TIMEOUT_EN
            exp_g = ((c / MAX_HOLD) % 2 == 0) ? 4'b0001 : 4'b0010;
`else
            exp_g = 4'b0001;
`endif
            chk_gnt("hold", exp_g);
            tick();
        end

        // Randomized traffic with occasional resets and sticky requests.
        for (int n = 0; n < 10000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 1) == 1) req = 4'($urandom);
            din = 4'($urandom);
            tick();
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mux4_rr_sched
`default_nettype wire

// File: doc/mux4_rr_sched.md
MUX4_RR_SCHED -- requirements
Module: mux4_rr_sched

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles per owner when timeout is compiled in; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req  input  4  per-requester request; bit k = requester k wants the shared 4:1 mux.
REQ-005 din  input  4  per-requester data bit; bit k is mux input k.
REQ-006 gnt  output  4  one-hot grant, registered; all-zero when idle.
REQ-007 sel  output  2  registered mux select = binary index of gnt owner; holds last value when idle.
REQ-008 y  output  1  registered mux output.
REQ-009 busy  output  1  registered; 1 while in GRANT.

Function
REQ-010 Two states SHALL exist: IDLE (no owner) and GRANT (one owner).
REQ-011 Round-robin pointer ptr[1:0] SHALL hold the last granted index; the search order SHALL be ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-012 IDLE: if req != 0 at edge t, SHALL go to GRANT at t+1 with gnt/sel = first requesting index in search order, ptr updated to that index; else stay IDLE.
REQ-013 GRANT, owner req still high and no forced rotate: gnt, sel, ptr SHALL hold.
REQ-014 GRANT, owner req low: if other requests pending, grant SHALL move to the next round-robin winner on the next edge with no idle cycle; else SHALL return to IDLE with gnt=0, busy=0.
REQ-015 The owner's own req bit SHALL be excluded from the winner search on release or forced rotation.
REQ-016 Request-to-grant latency SHALL be exactly 1 cycle from IDLE; a grant SHALL never be given to a requester whose req is low at the deciding edge.
REQ-017 y SHALL equal din[sel] sampled at the previous edge when busy was 1 at that edge, else 0 (1-cycle data latency).
REQ-018 gnt SHALL be one-hot or zero at all times; busy SHALL equal |gnt.
REQ-019 ptr wrap-around: after index 3 the search SHALL continue at index 0.

Reset
REQ-020 While rst_n=0 at an edge: state=IDLE, gnt=0, sel=0, y=0, busy=0, ptr=3, hold counter=0; requester 0 wins first after reset.
REQ-021 Reset asserted mid-grant SHALL drop the grant at that edge regardless of req.

Configuration
REQ-022 Macro MUX4_SCHED_TIMEOUT_EN compiles in an 8-bit hold counter.
REQ-023 With it: counter clears on every new grant, increments each GRANT cycle; when count = MAX_HOLD-1 and another req is pending, grant SHALL rotate at the next edge; if none pending, owner keeps grant and counter saturates.
REQ-024 Without it: no counter logic; owner keeps grant until its req drops; MAX_HOLD ignored.

Structure
REQ-025 Package mux4_sched_pkg SHALL hold the state type (IDLE, GRANT), N_REQ=4, SEL_W=2.
REQ-026 Sub-module rr_pick4 (combinational: req mask, ptr -> one-hot winner, index, valid) SHALL implement the search order.

Verification
REQ-027 Reset then req=0001 -> gnt=0001, sel=0, busy=1 one cycle later; din=0001 -> y=1 the cycle after.
REQ-028 req=1111 held, each owner drops req after 1 grant cycle -> grant order 0,1,2,3,0 with no idle gaps.
REQ-029 Owner 2 holds, req=0110, owner drops -> next grant 1 (wrap via 3,0,1), busy stays 1.
REQ-030 TIMEOUT_EN, MAX_HOLD=4, req=0011 held constant -> owner 0 holds 4 cycles, then grant 1 for 4 cycles, repeating; without macro -> owner 0 held indefinitely.
REQ-031 rst_n=0 for one cycle during grant of requester 3 -> gnt=0, y=0, busy=0 next edge; with req=1000 still high, regrant to 3 one cycle after reset release.
REQ-032 Random req/din for 10k cycles -> gnt always one-hot or zero, never to a non-requesting index, y matches 1-cycle-delayed din[sel].
